ccd_consumer_reader: RTL and testbench

- Consumer-side read controller for the async FIFO, clocked entirely in the consumer (CON_CLK) domain.
- Drains the FIFO read port under a fixed read-pacing rule: one read, then IDLE_CYCLES idle cycles. This models the consumer rate used in FIFO depth sizing.
- Re-times the 1-cycle-latency FIFO read data into a valid/ready stream through a small skid buffer.
- Counts words consumed, so benches can check them against producer totals.

---
 rtl/ccd_consumer_reader.sv | 111 +++++++++++
 tb/tb_ccd_consumer_reader.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccd_consumer_reader.sv
// Consumer-side async FIFO reader: paced reads, skid buffer, word count.
// Single clock domain (con_clk), synchronous active-high reset.
module ccd_consumer_reader #(
   parameter int DATA_WIDTH  = 8,
   parameter int IDLE_CYCLES = 1,
   parameter int BUF_DEPTH   = 2,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                  con_clk,
   input  logic                  con_rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic [CNT_WIDTH-1:0]  rd_count,
   output logic                  busy
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam int OW = PW + 1;
   localparam int GW = $clog2(IDLE_CYCLES + 2);
   localparam logic [OW-1:0] DEPTH = OW'(BUF_DEPTH);
   localparam logic [GW-1:0] GAP_LOAD =
      (IDLE_CYCLES > 0) ? GW'(IDLE_CYCLES - 1) : '0;

   typedef enum logic {
      S_ARMED,
      S_GAP
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [GW-1:0]         gap_cnt;
   logic [GW-1:0]         gap_nxt;
   logic                  pending;
   logic [OW-1:0]         occ;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
   logic                  room;
   logic                  rd_en;
   logic                  push;
   logic                  pop;

   // In-flight read counts as occupied; same-cycle pops free nothing.
   assign room = (occ + OW'(pending)) < DEPTH;
   assign push = pending;
   assign pop  = out_valid & out_ready;

   always_comb begin
      state_nxt = state;
      gap_nxt   = gap_cnt;
      rd_en     = 1'b0;
      case (state)
         S_ARMED: begin
            rd_en = enable & ~fifo_empty & room;
            if (rd_en && (IDLE_CYCLES > 0)) begin
               state_nxt = S_GAP;
               gap_nxt   = GAP_LOAD;
            end
         end
         S_GAP: begin
            if (gap_cnt == '0)
               state_nxt = S_ARMED;
            else
               gap_nxt = gap_cnt - GW'(1);
         end
         default: state_nxt = S_ARMED;
      endcase
   end

   always_ff @(posedge con_clk) begin
      if (con_rst) begin
         state    <= S_ARMED;
         gap_cnt  <= '0;
         pending  <= 1'b0;
         occ      <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rd_count <= '0;
         for (int i = 0; i < BUF_DEPTH; i++)
            mem[i] <= '0;
      end else begin
         state   <= state_nxt;
         gap_cnt <= gap_nxt;
         pending <= rd_en;
         if (rd_en)
            rd_count <= rd_count + CNT_WIDTH'(1);
         if (push) begin
            mem[wr_ptr] <= fifo_rd_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   occ <= occ + OW'(1);
            2'b01:   occ <= occ - OW'(1);
            default: occ <= occ;
         endcase
      end
   end

   assign fifo_rd_en = rd_en;
   assign out_valid  = (occ != '0);
   assign out_data   = mem[rd_ptr];
   assign busy       = pending | (occ != '0) | (state == S_GAP);

endmodule

// File: tb/tb_ccd_consumer_reader.sv
// Bench for ccd_consumer_reader: table, directed corners, random vs model.
// Instance 0: IDLE=1 BUF=2 CNT=16; instance 1: IDLE=0 BUF=4 CNT=4.
module tb_ccd_consumer_reader;

   localparam int M = 4095;

   typedef struct {
      logic       en;
      logic       rdy;
      logic       rd;
      logic       vld;
      logic [7:0] dat;
      logic       bsy;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       en[2];
   logic       emp[2];
   logic       rd[2];
   logic       vld[2];
   logic       rdy[2];
   logic       bsy[2];
   logic [7:0] rdat[2];
   logic [7:0] dout[2];
   logic [15:0] cnt_a;
   logic [3:0]  cnt_b;
   logic       hold_emp[2];

   int tests = 0;
   int fails = 0;
   int kk[2];
   int bd[2];
   int cyc;
   int last[2];
   int rc[2];
   int rds[2];
   int dl[2];
   int fhead[2];
   int ftail[2];
   int ehead[2];
   int etail[2];
   logic [7:0] fmem[2][4096];
   logic [7:0] edat[2][4096];
   int         ecyc[2][4096];
   logic       rdv[2];
   logic       popv[2];
   vec_t       tbl[8];

   always #5 clk = ~clk;

   ccd_consumer_reader #(
      .DATA_WIDTH(8), .IDLE_CYCLES(1), .BUF_DEPTH(2), .CNT_WIDTH(16)
   ) u_a (
      .con_clk(clk), .con_rst(rst), .enable(en[0]),
      .fifo_empty(emp[0]), .fifo_rd_en(rd[0]),
      .fifo_rd_data(rdat[0]), .out_valid(vld[0]),
      .out_data(dout[0]), .out_ready(rdy[0]),
      .rd_count(cnt_a), .busy(bsy[0])
   );

   ccd_consumer_reader #(
      .DATA_WIDTH(8), .IDLE_CYCLES(0), .BUF_DEPTH(4), .CNT_WIDTH(4)
   ) u_b (
      .con_clk(clk), .con_rst(rst), .enable(en[1]),
      .fifo_empty(emp[1]), .fifo_rd_en(rd[1]),
      .fifo_rd_data(rdat[1]), .out_valid(vld[1]),
      .out_data(dout[1]), .out_ready(rdy[1]),
      .rd_count(cnt_b), .busy(bsy[1])
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  nm, act, want, cyc);
      end
   endtask

   function automatic int esize(input int i);
      return etail[i] - ehead[i];
   endfunction

   function automatic int fsize(input int i);
      return ftail[i] - fhead[i];
   endfunction

   task automatic upd_emp(input int i);
      emp[i] = hold_emp[i] || (ftail[i] == fhead[i]);
   endtask

   task automatic push_w(input int i, input logic [7:0] d);
      fmem[i][ftail[i] & M] = d;
      ftail[i]++;
      upd_emp(i);
   endtask

   // Reference: a word read at cycle c is visible from c+2 until taken;
   // reads allowed when enabled, non-empty, outstanding < depth and
   // more than k cycles since the previous read.
   task automatic sample();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         int sn;
         logic er, ev, eb;
         logic [15:0] ec, ac;
         sn = cyc - last[i];
         er = en[i] && !emp[i] && (esize(i) < bd[i]) && (sn > kk[i]);
         ev = (esize(i) > 0) && ((cyc - ecyc[i][ehead[i] & M]) >= 2);
         eb = (esize(i) > 0) || (sn >= 1 && sn <= kk[i]);
         ec = (i == 0) ? 16'(rc[i]) : 16'(rc[i] & 15);
         ac = (i == 0) ? cnt_a : {12'b0, cnt_b};
         chk($sformatf("rd_en%0d", i), 32'(rd[i]), 32'(er));
         chk($sformatf("valid%0d", i), 32'(vld[i]), 32'(ev));
         chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(eb));
         chk($sformatf("rd_count%0d", i), 32'(ac), 32'(ec));
         if (ev)
            chk($sformatf("data%0d", i), 32'(dout[i]),
                32'(edat[i][ehead[i] & M]));
         rdv[i]  = rd[i];
         popv[i] = ev && rdy[i];
      end
   endtask

   task automatic clk_edge();
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         logic [7:0] d;
         d = 8'h00;
         if (rdv[i] && fsize(i) > 0) begin
            d = fmem[i][fhead[i] & M];
            fhead[i]++;
            rdat[i] = d;
         end
         if (rst) begin
            ehead[i] = etail[i];
            rc[i]    = 0;
            rds[i]   = 0;
            dl[i]    = 0;
            last[i]  = -100;
         end else begin
            if (popv[i]) begin
               ehead[i]++;
               dl[i]++;
            end
            if (rdv[i]) begin
               edat[i][etail[i] & M] = d;
               ecyc[i][etail[i] & M] = cyc;
               etail[i]++;
               rc[i]++;
               rds[i]++;
               last[i] = cyc;
            end
         end
         upd_emp(i);
      end
      cyc++;
   endtask

   task automatic tick();
      sample();
      clk_edge();
   endtask

   task automatic run(input int n, input int i, output int nrd);
      nrd = 0;
      repeat (n) begin
         sample();
         nrd += int'(rdv[i]);
         clk_edge();
      end
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      en[0] = 1'b0;
      en[1] = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         fhead[i]    = ftail[i];
         hold_emp[i] = 1'b0;
         rdy[i]      = 1'b1;
         upd_emp(i);
      end
   endtask

   task automatic wait_rd(input string nm);
      int   w;
      logic seen;
      w    = 0;
      seen = 1'b0;
      while (!seen && w < 10) begin
         sample();
         seen = rdv[0];
         clk_edge();
         w++;
      end
      chk(nm, 32'(seen), 32'd1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      int   w;
      logic done;
      logic [7:0] hold;

      tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
      tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
      tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 1'b1};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 1'b1};
      tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

      kk[0] = 1;
      kk[1] = 0;
      bd[0] = 2;
      bd[1] = 4;
      cyc   = 0;
      for (int i = 0; i < 2; i++) begin
         last[i] = -100;
         rc[i] = 0; rds[i] = 0; dl[i] = 0;
         fhead[i] = 0; ftail[i] = 0;
         ehead[i] = 0; etail[i] = 0;
         en[i] = 1'b0; rdy[i] = 1'b1;
         hold_emp[i] = 1'b0;
         rdat[i] = 8'h00;
         rdv[i] = 1'b0; popv[i] = 1'b0;
         upd_emp(i);
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      sample();
      chk("rst_rd_en", 32'(rd[0]), 0);
      chk("rst_valid", 32'(vld[0]), 0);
      chk("rst_data", 32'(dout[0]), 0);
      chk("rst_count", 32'(cnt_a), 0);
      chk("rst_busy", 32'(bsy[0]), 0);
      clk_edge();

      push_w(0, 8'h01);
      push_w(0, 8'h02);
      push_w(0, 8'h03);
      for (int r = 0; r < 8; r++) begin
         en[0]  = tbl[r].en;
         rdy[0] = tbl[r].rdy;
         sample();
         chk($sformatf("tbl%0d_rd", r), 32'(rd[0]), 32'(tbl[r].rd));
         chk($sformatf("tbl%0d_vld", r), 32'(vld[0]), 32'(tbl[r].vld));
         chk($sformatf("tbl%0d_bsy", r), 32'(bsy[0]), 32'(tbl[r].bsy));
         if (tbl[r].vld)
            chk($sformatf("tbl%0d_dat", r), 32'(dout[0]),
                32'(tbl[r].dat));
         clk_edge();
      end

      do_reset();
      for (int k = 1; k <= 10; k++)
         push_w(0, 8'(k));
      en[0] = 1'b1;
      run(50, 0, n);
      chk("pace_reads", n, 10);
      chk("pace_count", 32'(cnt_a), 10);
      chk("pace_deliv", dl[0], 10);
      sample();
      chk("pace_idle", 32'(bsy[0]), 0);
      clk_edge();

      do_reset();
      for (int k = 0; k < 6; k++)
         push_w(0, 8'h10 + 8'(k));
      en[0]  = 1'b1;
      rdy[0] = 1'b0;
      run(10, 0, n);
      chk("bp_reads", n, 2);
      sample();
      hold = dout[0];
      clk_edge();
      run(5, 0, n);
      sample();
      chk("bp_stable", 32'(dout[0]), 32'(hold));
      chk("bp_valid", 32'(vld[0]), 1);
      clk_edge();
      rdy[0] = 1'b1;
      run(30, 0, n);
      chk("bp_deliv", dl[0], 6);
      chk("bp_total", rds[0], 6);

      do_reset();
      hold_emp[0] = 1'b1;
      for (int k = 0; k < 4; k++)
         push_w(0, 8'h30 + 8'(k));
      en[0] = 1'b1;
      run(20, 0, n);
      chk("empty_reads", n, 0);
      hold_emp[0] = 1'b0;
      upd_emp(0);
      run(20, 0, n);
      chk("refill_reads", n, 4);

      do_reset();
      for (int k = 0; k < 8; k++)
         push_w(0, 8'h40 + 8'(k));
      en[0] = 1'b1;
      wait_rd("endrop_wait");
      en[0] = 1'b0;
      run(20, 0, n);
      chk("endrop_reads", n, 0);
      chk("endrop_deliv", dl[0], rds[0]);

      do_reset();
      push_w(0, 8'hA1);
      push_w(0, 8'hA2);
      push_w(0, 8'hA3);
      en[0] = 1'b1;
      wait_rd("rstmid_wait");
      rst   = 1'b1;
      en[0] = 1'b0;
      tick();
      rst = 1'b0;
      sample();
      chk("rstmid_rd", 32'(rd[0]), 0);
      chk("rstmid_vld", 32'(vld[0]), 0);
      chk("rstmid_dat", 32'(dout[0]), 0);
      chk("rstmid_cnt", 32'(cnt_a), 0);
      chk("rstmid_bsy", 32'(bsy[0]), 0);
      clk_edge();
      run(5, 0, n);
      en[0] = 1'b1;
      run(20, 0, n);
      chk("rstmid_deliv", dl[0], 2);

      do_reset();
      for (int k = 0; k < 20; k++)
         push_w(1, 8'h60 + 8'(k));
      en[1] = 1'b1;
      run(40, 1, n);
      chk("b2b_reads", n, 20);
      chk("b2b_wrap", 32'(cnt_b), 4);
      chk("b2b_deliv", dl[1], 20);

      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 2; i++) begin
            en[i]  = ($urandom_range(7) != 0);
            rdy[i] = ($urandom_range(2) != 0);
            if ($urandom_range(3) == 0)
               push_w(i, 8'($urandom));
            if ($urandom_range(15) == 0)
               hold_emp[i] = ~hold_emp[i];
            upd_emp(i);
         end
         rst = ($urandom_range(499) == 0);
         tick();
      end

      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         hold_emp[i] = 1'b0;
         en[i]       = 1'b1;
         rdy[i]      = 1'b1;
         upd_emp(i);
      end
      w    = 0;
      done = 1'b0;
      while (!done && w < 5000) begin
         tick();
         w++;
         done = (fsize(0) == 0) && (esize(0) == 0) &&
                (fsize(1) == 0) && (esize(1) == 0);
      end
      chk("drain_done", 32'(done), 1);
      chk("rand_conserve0", dl[0], rds[0]);
      chk("rand_conserve1", dl[1], rds[1]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
